// File: rtl/eif_pkg.sv
// Shared constants and arithmetic helpers for the time-multiplexed AdEx neuron array.
// Default neuron constants match the single-neuron core this array replaces.
package eif_pkg;

    localparam int DEF_N_NEURONS   = 4;
    localparam int DEF_W           = 8;
    localparam int DEF_SW          = DEF_W + 3;
    localparam int DEF_V_REST      = 16;
    localparam int DEF_V_RESET     = 8;
    localparam int DEF_V_T         = 120;
    localparam int DEF_THRESH      = 200;
    localparam int DEF_LEAK_SHIFT  = 3;
    localparam int DEF_EXP_SHIFT   = 3;
    localparam int DEF_ADAPT_INC   = 8;
    localparam int DEF_ADAPT_SHIFT = 4;
    localparam int DEF_REFRAC_UPD  = 2;

    // Minimum of 1 so a single-channel array still gets a real select/index bit.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    function automatic int clamp_int(input int x, input int lo, input int hi);
        if (x < lo) return lo;
        if (x > hi) return hi;
        return x;
    endfunction

    function automatic int sat_max(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/eif_neuron_array_if.sv
// Channel-side bus of the neuron array: enable, per-channel currents, observation
// select and the registered outputs.
interface eif_neuron_array_if
    import eif_pkg::*;
#(
    parameter int N_NEURONS = DEF_N_NEURONS,
    parameter int W         = DEF_W
);
    localparam int IW = clog2(N_NEURONS);

    logic                     ena;
    logic [N_NEURONS*W-1:0]   cur_in;
    logic [IW-1:0]            obs_sel;
    logic [W-1:0]             obs_v;
    logic [N_NEURONS-1:0]     spike_out;
    logic                     frame;

    modport master (
        output ena, cur_in, obs_sel,
        input  obs_v, spike_out, frame
    );

    modport slave (
        input  ena, cur_in, obs_sel,
        output obs_v, spike_out, frame
    );

endinterface

// File: rtl/eif_update_core.sv
// Combinational AdEx update for one neuron, shared round-robin by all channels.
// Arithmetic runs in W+3-bit signed so the pre-clamp sum can neither wrap nor go unsigned.
module eif_update_core
    import eif_pkg::*;
#(
    parameter int W           = DEF_W,
    parameter int RW          = 2,
    parameter int V_REST      = DEF_V_REST,
    parameter int V_RESET     = DEF_V_RESET,
    parameter int V_T         = DEF_V_T,
    parameter int THRESH      = DEF_THRESH,
    parameter int LEAK_SHIFT  = DEF_LEAK_SHIFT,
    parameter int EXP_SHIFT   = DEF_EXP_SHIFT,
    parameter int ADAPT_INC   = DEF_ADAPT_INC,
    parameter int ADAPT_SHIFT = DEF_ADAPT_SHIFT,
    parameter int REFRAC_UPD  = DEF_REFRAC_UPD
)(
    input  logic [W-1:0]  v,
    input  logic [W-1:0]  w,
    input  logic [RW-1:0] refrac,
    input  logic [W-1:0]  cur,
    output logic [W-1:0]  v_next,
    output logic [W-1:0]  w_next,
    output logic [RW-1:0] refrac_next,
    output logic          spike
);
    localparam int SW    = W + 3;
    localparam int MAX_W = sat_max(W);

    typedef logic signed [SW-1:0] acc_t;

    localparam acc_t         VREST_S  = acc_t'(V_REST);
    localparam logic [W-1:0] VT_W     = W'(V_T);
    localparam logic [W-1:0] VRESET_W = W'(V_RESET);
    localparam logic [W-1:0] TH_W     = W'(THRESH);
    localparam logic [W-1:0] EXP_MAX  = W'(W - 1);

    acc_t         v_s;
    acc_t         leak;
    acc_t         exp_term;
    acc_t         sum;
    logic [W-1:0] over_sh;
    logic [W-1:0] v_clamp;
    logic [W-1:0] w_decay;

    always_comb begin
        v_s      = acc_t'(v);
        leak     = (v_s - VREST_S) >>> LEAK_SHIFT;
        over_sh  = (v - VT_W) >> EXP_SHIFT;
        exp_term = '0;
        if (v > VT_W)
            exp_term = acc_t'(1) << ((over_sh > EXP_MAX) ? EXP_MAX : over_sh);
        sum      = v_s + acc_t'(cur) - leak - acc_t'(w) + exp_term;
        v_clamp  = W'(clamp_int(int'(sum), 0, MAX_W));
        w_decay  = w - (w >> ADAPT_SHIFT);

        v_next      = v;
        w_next      = w_decay;
        refrac_next = refrac;
        spike       = 1'b0;

        // Refractory updates leave v parked at V_RESET and skip the threshold test.
        if (refrac != '0) begin
            refrac_next = refrac - RW'(1);
        end else if (v_clamp >= TH_W) begin
            spike       = 1'b1;
            v_next      = VRESET_W;
            w_next      = W'(clamp_int(int'(w_decay) + ADAPT_INC, 0, MAX_W));
            refrac_next = RW'(REFRAC_UPD);
        end else begin
            v_next = v_clamp;
        end
    end

endmodule

// File: rtl/eif_neuron_array.sv
// N-channel AdEx neuron array: per-channel state registers, round-robin scan counter,
// output registers and the observation mux around one shared update core.
module eif_neuron_array
    import eif_pkg::*;
#(
    parameter int N_NEURONS   = DEF_N_NEURONS,
    parameter int W           = DEF_W,
    parameter int V_REST      = DEF_V_REST,
    parameter int V_RESET     = DEF_V_RESET,
    parameter int V_T         = DEF_V_T,
    parameter int THRESH      = DEF_THRESH,
    parameter int LEAK_SHIFT  = DEF_LEAK_SHIFT,
    parameter int EXP_SHIFT   = DEF_EXP_SHIFT,
    parameter int ADAPT_INC   = DEF_ADAPT_INC,
    parameter int ADAPT_SHIFT = DEF_ADAPT_SHIFT,
    parameter int REFRAC_UPD  = DEF_REFRAC_UPD
)(
    input  logic              clk,
    input  logic              rst_n,
    eif_neuron_array_if.slave io
);
    localparam int IW = clog2(N_NEURONS);
    localparam int RW = clog2(REFRAC_UPD + 1);

    localparam logic [W-1:0]  V_REST_W = W'(V_REST);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_NEURONS - 1);

    logic [W-1:0]         v_q [N_NEURONS];
    logic [W-1:0]         w_q [N_NEURONS];
    logic [RW-1:0]        r_q [N_NEURONS];
    logic [IW-1:0]        idx;
    logic [N_NEURONS-1:0] spike_q;
    logic                 frame_q;
    logic [W-1:0]         obs_q;

    logic [W-1:0]  v_cur, w_cur, cur_sel, obs_nx;
    logic [RW-1:0] r_cur;
    logic [W-1:0]  v_nx, w_nx;
    logic [RW-1:0] r_nx;
    logic          spk_nx;

    // Explicit compare-mux keeps out-of-range selects (obs_sel >= N) reading as 0.
    always_comb begin
        v_cur   = '0;
        w_cur   = '0;
        r_cur   = '0;
        cur_sel = '0;
        obs_nx  = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            if (idx == IW'(i)) begin
                v_cur   = v_q[i];
                w_cur   = w_q[i];
                r_cur   = r_q[i];
                cur_sel = io.cur_in[i*W +: W];
            end
            if (io.obs_sel == IW'(i))
                obs_nx = v_q[i];
        end
    end

    eif_update_core #(
        .W           (W),
        .RW          (RW),
        .V_REST      (V_REST),
        .V_RESET     (V_RESET),
        .V_T         (V_T),
        .THRESH      (THRESH),
        .LEAK_SHIFT  (LEAK_SHIFT),
        .EXP_SHIFT   (EXP_SHIFT),
        .ADAPT_INC   (ADAPT_INC),
        .ADAPT_SHIFT (ADAPT_SHIFT),
        .REFRAC_UPD  (REFRAC_UPD)
    ) u_core (
        .v           (v_cur),
        .w           (w_cur),
        .refrac      (r_cur),
        .cur         (cur_sel),
        .v_next      (v_nx),
        .w_next      (w_nx),
        .refrac_next (r_nx),
        .spike       (spk_nx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                v_q[i] <= V_REST_W;
                w_q[i] <= '0;
                r_q[i] <= '0;
            end
            idx     <= '0;
            spike_q <= '0;
            frame_q <= 1'b0;
            obs_q   <= V_REST_W;
        end else begin
            obs_q   <= obs_nx;
            frame_q <= io.ena && (idx == IDX_LAST);
            if (io.ena) begin
                for (int i = 0; i < N_NEURONS; i++) begin
                    if (idx == IW'(i)) begin
                        v_q[i]     <= v_nx;
                        w_q[i]     <= w_nx;
                        r_q[i]     <= r_nx;
                        spike_q[i] <= spk_nx;
                    end
                end
                idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end
        end
    end

    assign io.obs_v     = obs_q;
    assign io.spike_out = spike_q;
    assign io.frame     = frame_q;

endmodule
